// File: rtl/fourbit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fourbit_pkg
// Description : Shared types and constants for the 4-bit CPU program loader:
//               loader state encoding, default widths and program depth.
// Revision    : 1.0 - initial release
// ============================================================================
package fourbit_pkg;

  localparam int DEFAULT_INST_W = 8;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int PROG_DEPTH     = 16;

  // ERROR is only reachable when PROG_CKSUM_EN is defined
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Program byte-stream load channel. The producer (master) drives
//               start/valid/data; the loader (slave) answers ready/done/err.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if
  import fourbit_pkg::*;
#(
  parameter int INST_W = DEFAULT_INST_W
);
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [INST_W-1:0] ld_data;
  logic              ld_done;
  logic              ld_err;

  modport master (
    output ld_start, ld_valid, ld_data,
    input  ld_ready, ld_done, ld_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data,
    output ld_ready, ld_done, ld_err
  );
endinterface
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem
// Description : Instruction store, 2^ADDR_W x INST_W registers. Async
//               active-low clear, one synchronous write port, one
//               asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem
  import fourbit_pkg::*;
#(
  parameter int INST_W = DEFAULT_INST_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [INST_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [INST_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] mem [DEPTH];

  // Clear the whole program on reset, otherwise single-port write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Program store and loader for the 4-bit CPU. Feeds inst from
//               pc, accepts a 16-byte program over a valid/ready stream and
//               holds the CPU in reset until loaded or run is commanded.
//               Optional feature macro: PROG_CKSUM_EN (XOR checksum byte
//               after the program, ERROR state on mismatch).
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import fourbit_pkg::*;
#(
  parameter int INST_W = DEFAULT_INST_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  wire logic              clk_cpu,
  input  wire logic              reset,
  input  wire logic [ADDR_W-1:0] pc,
  output logic      [INST_W-1:0] inst,
  output logic                   cpu_hold,
  input  wire logic              run,
  prog_loader_if.slave           ld_if
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ld_state_t         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              xfer;
  logic              mem_we;

  // A byte moves only while ready; a restart in the same cycle drops it
  assign xfer = ld_if.ld_valid && ld_ready_q && !ld_if.ld_start;

`ifdef PROG_CKSUM_EN
  logic [INST_W-1:0] cksum_acc;
  logic              cksum_phase;   // next byte is the checksum, not program
  logic              ld_err_q;

  assign mem_we       = xfer && !cksum_phase;
  assign ld_if.ld_err = ld_err_q;

  // Loader FSM with pointer, checksum and registered Moore outputs
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state       <= ST_HOLD;
      wr_ptr      <= '0;
      cpu_hold    <= 1'b1;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      cksum_acc   <= '0;
      cksum_phase <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      if (ld_if.ld_start) begin
        // Any state enters (or restarts) LOAD on a start pulse
        state       <= ST_LOAD;
        wr_ptr      <= '0;
        cksum_acc   <= '0;
        cksum_phase <= 1'b0;
        cpu_hold    <= 1'b1;
        ld_ready_q  <= 1'b1;
        ld_err_q    <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (run) begin
              state    <= ST_RUN;
              cpu_hold <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (xfer) begin
              if (cksum_phase) begin
                cksum_phase <= 1'b0;
                ld_ready_q  <= 1'b0;
                if (ld_if.ld_data == cksum_acc) begin
                  state     <= ST_RUN;
                  cpu_hold  <= 1'b0;
                  ld_done_q <= 1'b1;
                end else begin
                  state    <= ST_ERROR;
                  ld_err_q <= 1'b1;
                end
              end else begin
                wr_ptr    <= wr_ptr + 1'b1;
                cksum_acc <= cksum_acc ^ ld_if.ld_data;
                if (wr_ptr == LAST_ADDR) cksum_phase <= 1'b1;
              end
            end
          end
          ST_RUN:   ;
          ST_ERROR: ;
          default: begin
            state      <= ST_HOLD;
            cpu_hold   <= 1'b1;
            ld_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end
`else
  assign mem_we       = xfer;
  assign ld_if.ld_err = 1'b0;

  // Loader FSM with pointer and registered Moore outputs
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state      <= ST_HOLD;
      wr_ptr     <= '0;
      cpu_hold   <= 1'b1;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      if (ld_if.ld_start) begin
        // Any state enters (or restarts) LOAD on a start pulse
        state      <= ST_LOAD;
        wr_ptr     <= '0;
        cpu_hold   <= 1'b1;
        ld_ready_q <= 1'b1;
      end else begin
        case (state)
          ST_HOLD: begin
            if (run) begin
              state    <= ST_RUN;
              cpu_hold <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (xfer) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == LAST_ADDR) begin
                state      <= ST_RUN;
                cpu_hold   <= 1'b0;
                ld_ready_q <= 1'b0;
                ld_done_q  <= 1'b1;
              end
            end
          end
          ST_RUN: ;
          default: begin
            state      <= ST_HOLD;
            cpu_hold   <= 1'b1;
            ld_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end
`endif

  assign ld_if.ld_ready = ld_ready_q;
  assign ld_if.ld_done  = ld_done_q;

  prog_mem #(
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk_cpu),
    .rst_n (reset),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (ld_if.ld_data),
    .raddr (pc),
    .rdata (inst)
  );
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Random valid patterns and
//               program bytes against an array model of the program store.
//               Define PROG_CKSUM_EN to exercise the checksum variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  import fourbit_pkg::*;

  localparam int IW = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk_cpu = 1'b0;
  logic          reset   = 1'b0;
  logic          run     = 1'b0;
  logic [AW-1:0] pc      = '0;
  logic [IW-1:0] inst;
  logic          cpu_hold;

  prog_loader_if #(.INST_W(IW)) ld_if ();

  prog_loader #(.INST_W(IW), .ADDR_W(AW)) dut (
    .clk_cpu  (clk_cpu),
    .reset    (reset),
    .pc       (pc),
    .inst     (inst),
    .cpu_hold (cpu_hold),
    .run      (run),
    .ld_if    (ld_if)
  );

  always #5 clk_cpu = ~clk_cpu;

  logic [IW-1:0] ref_mem [N];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #2;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < N; a++) begin
      pc = a[AW-1:0];
      #1;
      check($sformatf("%s[%0d]", tag, a), 32'(inst), 32'(ref_mem[a]));
    end
    tick();
  endtask

  // pattern: 0 random, 1 ascending 8'h10.., 2 all 8'hA5
  task automatic do_load(input int pattern, input bit toggle, input int restart_at,
                         input bit bad_cks, input bit with_run);
    logic [IW-1:0] bytes [N+1];
    logic [IW-1:0] x;
    int  nb, k, cyc;
    bit  v, restarted, exp_ok;
    x = '0;
    for (int i = 0; i < N; i++) begin
      case (pattern)
        1:       bytes[i] = IW'(8'h10 + i);
        2:       bytes[i] = 8'hA5;
        default: bytes[i] = IW'($urandom);
      endcase
      x ^= bytes[i];
    end
    nb     = N;
    exp_ok = 1'b1;
`ifdef PROG_CKSUM_EN
    nb       = N + 1;
    bytes[N] = x ^ (bad_cks ? 8'h01 : 8'h00);
    exp_ok   = !bad_cks;
`endif

    ld_if.ld_start = 1'b1;
    run            = with_run;
    tick();
    ld_if.ld_start = 1'b0;
    run            = 1'b0;
    check("start_hold",  32'(cpu_hold),       32'd1);
    check("start_ready", 32'(ld_if.ld_ready), 32'd1);
    check("start_err",   32'(ld_if.ld_err),   32'd0);

    k = 0; cyc = 0; restarted = 1'b0;
    while (k < nb && cyc < 400) begin
      if (!restarted && k == restart_at) begin
        ld_if.ld_start = 1'b1;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 8'hEE;
        tick();
        ld_if.ld_start = 1'b0;
        restarted = 1'b1;
        k = 0;
        cyc++;
        check("restart_ready", 32'(ld_if.ld_ready), 32'd1);
        pc = AW'(restart_at);
        #1;
        check("restart_drop", 32'(inst), 32'(ref_mem[restart_at]));
        continue;
      end
      v = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      if (cyc > 200) v = 1'b1;
      run            = 1'($urandom_range(0, 1));
      ld_if.ld_valid = v;
      ld_if.ld_data  = v ? bytes[k] : IW'($urandom);
      tick();
      cyc++;
      if (v) begin
        if (k < N) begin
          ref_mem[k] = bytes[k];
          pc = AW'(k);
          #1;
          check("wr_visible", 32'(inst), 32'(bytes[k]));
        end
        k++;
      end
      if (k < nb) begin
        check("busy_done", 32'(ld_if.ld_done), 32'd0);
        check("busy_hold", 32'(cpu_hold),      32'd1);
      end
    end
    ld_if.ld_valid = 1'b0;
    run            = 1'b0;
    check("load_budget", 32'(k),              32'(nb));
    check("end_done",    32'(ld_if.ld_done),  32'(exp_ok));
    check("end_hold",    32'(cpu_hold),       32'(!exp_ok));
    check("end_ready",   32'(ld_if.ld_ready), 32'd0);
    check("end_err",     32'(ld_if.ld_err),   32'(!exp_ok));
    tick();
    check("done_pulse",  32'(ld_if.ld_done),  32'd0);
    check_mem("mem");
  endtask

  initial begin
    ld_if.ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_hold",  32'(cpu_hold),       32'd1);
    check("rst_ready", 32'(ld_if.ld_ready), 32'd0);
    check("rst_done",  32'(ld_if.ld_done),  32'd0);
    check("rst_err",   32'(ld_if.ld_err),   32'd0);
    reset = 1'b1;
    tick();
    check("hold_idle", 32'(cpu_hold), 32'd1);

    // Run without loading
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run_hold",  32'(cpu_hold),       32'd0);
    check("run_ready", 32'(ld_if.ld_ready), 32'd0);
    check_mem("empty");

    // Stream ignored outside LOAD, run ignored in RUN
    for (int i = 0; i < 3; i++) begin
      run            = 1'b1;
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = 8'hFF;
      tick();
    end
    run            = 1'b0;
    ld_if.ld_valid = 1'b0;
    check("idle_hold", 32'(cpu_hold), 32'd0);
    check_mem("idle");

    // Directed loads
    do_load(1, 1'b0, -1, 1'b0, 1'b0);
    pc = 4'd4;
    #1;
    check("seq_pc4", 32'(inst), 32'h14);
    tick();
    do_load(1, 1'b1, -1, 1'b0, 1'b0);
    do_load(0, 1'b0, 5, 1'b0, 1'b0);

    // Random loads
    for (int r = 0; r < 4; r++) do_load(0, 1'b0, -1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a load
    ld_if.ld_start = 1'b1;
    tick();
    ld_if.ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = IW'($urandom);
      tick();
    end
    ld_if.ld_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("arst_hold",  32'(cpu_hold),       32'd1);
    check("arst_ready", 32'(ld_if.ld_ready), 32'd0);
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    check_mem("arst");
    reset = 1'b1;
    tick();

    // Start and run together in HOLD: start wins
    do_load(0, 1'b0, -1, 1'b0, 1'b1);

`ifdef PROG_CKSUM_EN
    do_load(2, 1'b0, -1, 1'b0, 1'b0);
    do_load(0, 1'b0, -1, 1'b1, 1'b0);
    tick(); tick();
    check("err_level", 32'(ld_if.ld_err), 32'd1);
    check("err_hold",  32'(cpu_hold),     32'd1);
    do_load(0, 1'b0, -1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
